// File: rtl/vldrdy_pkg.sv
// rtl/vldrdy_pkg.sv - shared types and round-robin pick helper for vldrdy arbiters
package vldrdy_pkg;

    // Widest request vector the shared pick helper handles.
    localparam int MAX_SRC = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First requester after 'last', scanning last+1, last+2, ... modulo nsrc.
    // Callers zero-extend narrower request vectors to MAX_SRC bits.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_SRC-1:0]   req,
        input logic [MAX_IDX_W-1:0] last,
        input int                   nsrc
    );
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            if ((k <= nsrc) && !res.found) begin
                cand = (int'(last) + k) % nsrc;
                if (req[cand[MAX_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[MAX_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// rtl/rr_prio_sel.sv - combinational round-robin priority selector
module rr_prio_sel
    import vldrdy_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NSRC-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [MAX_SRC-1:0]   req_ext;
    logic [MAX_IDX_W-1:0] last_ext;
    rr_pick_t             pick;
    logic                 unused_pick_bits;

    // Widen to the helper's fixed width, pick, then narrow the index back.
    always_comb begin
        req_ext             = '0;
        req_ext[NSRC-1:0]   = req;
        last_ext            = '0;
        last_ext[IDX_W-1:0] = last;
        pick                = rr_pick(req_ext, last_ext, NSRC);
        idx                 = pick.idx[IDX_W-1:0];
        found               = pick.found;
    end

    // Upper index bits are always zero because the pick is below NSRC.
    assign unused_pick_bits = &{1'b0, pick.idx};

endmodule

// File: rtl/vldrdy_rr_arbiter.sv
// rtl/vldrdy_rr_arbiter.sv - round-robin burst arbiter from NSRC valid/ready sources to one sink
module vldrdy_rr_arbiter
    import vldrdy_pkg::*;
#(
    parameter  int NSRC      = 4,
    parameter  int DWIDTH    = 8,
    parameter  int BURST_LEN = 4,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_en,
    input  logic [NSRC-1:0]        src_val,
    output logic [NSRC-1:0]        src_rdy,
    input  logic [NSRC*DWIDTH-1:0] src_data,
    output logic                   dst_val,
    input  logic                   dst_rdy,
    output logic [DWIDTH-1:0]      dst_data,
    output logic                   gnt_vld,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic [CNT_W-1:0]       beat_cnt
);

    localparam int               BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]    BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NSRC - 1);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  gnt_idx_q;
    logic [IDX_W-1:0]  last_gnt_q;
    logic [BW-1:0]     burst_cnt_q;
    logic [BW-1:0]     burst_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  beat_cnt_d;

    logic [DWIDTH-1:0] src_arr [NSRC];
    logic              busy;
    logic              pass_en;
    logic              cur_val;
    logic [DWIDTH-1:0] cur_data;
    logic              hs;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;

    for (genvar g = 0; g < NSRC; g++) begin : g_unpack
        assign src_arr[g] = src_data[g*DWIDTH +: DWIDTH];
    end

    // Reset is folded into the pass gate so no beat is taken during a reset cycle.
    assign pass_en  = cfg_en & rst_n;
    assign busy     = (state_q == BUSY);
    assign cur_val  = src_val[gnt_idx_q];
    assign cur_data = src_arr[gnt_idx_q];

    // Route the granted source to the sink; everything else sees ready low.
    always_comb begin
        dst_val  = busy & pass_en & cur_val;
        dst_data = busy ? cur_data : '0;
        src_rdy  = '0;
        if (busy && pass_en) begin
            src_rdy[gnt_idx_q] = dst_rdy;
        end
    end

    assign hs          = dst_val & dst_rdy;
    assign burst_cnt_d = burst_cnt_q + 1'b1;
    assign beat_cnt_d  = beat_cnt_q + 1'b1;

    rr_prio_sel #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .req   (src_val),
        .last  (last_gnt_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grant FSM: arbitrate in IDLE, stream a burst in BUSY, always return to IDLE between bursts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            last_gnt_q  <= IDX_LAST;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (hs) begin
                beat_cnt_q <= beat_cnt_d;
            end
            if (!cfg_en) begin
                state_q     <= IDLE;
                burst_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pick_found) begin
                            gnt_idx_q   <= pick_idx;
                            burst_cnt_q <= '0;
                            state_q     <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (hs) begin
                            if (burst_cnt_q == BURST_LAST) begin
                                last_gnt_q <= gnt_idx_q;
                                state_q    <= IDLE;
                            end else begin
                                burst_cnt_q <= burst_cnt_d;
                            end
                        end else if (!cur_val) begin
                            // Source went quiet: release early so others are not starved.
                            last_gnt_q <= gnt_idx_q;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign gnt_vld  = busy;
    assign gnt_idx  = gnt_idx_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_vldrdy_rr_arbiter.sv
// tb/tb_vldrdy_rr_arbiter.sv - scoreboard bench for vldrdy_rr_arbiter
module tb_vldrdy_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   = 1'b0;
    logic        cfg_en  = 1'b0;
    logic        dst_rdy = 1'b0;
    logic        sel     = 1'b0;
    logic [3:0]  src_val = '0;
    logic [3:0]  en_src  = 4'hF;
    logic [31:0] a_src_data = '0;
    logic [63:0] b_src_data = '0;

    logic [3:0]  a_src_rdy, b_src_rdy;
    logic        a_dst_val, b_dst_val;
    logic [7:0]  a_dst_data;
    logic [15:0] b_dst_data;
    logic        a_gnt_vld, b_gnt_vld;
    logic [1:0]  a_gnt_idx, b_gnt_idx;
    logic [15:0] a_beat_cnt, b_beat_cnt;

    logic [15:0] srcq [4][$];
    logic [19:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_cyc;

    logic        o_dval, o_gvld, o_hs;
    logic [15:0] o_data, o_beat;
    logic [1:0]  o_gidx;
    logic [3:0]  o_srdy;

    vldrdy_rr_arbiter #(.NSRC(4), .DWIDTH(8), .BURST_LEN(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
        .src_val(src_val), .src_rdy(a_src_rdy), .src_data(a_src_data),
        .dst_val(a_dst_val), .dst_rdy(dst_rdy), .dst_data(a_dst_data),
        .gnt_vld(a_gnt_vld), .gnt_idx(a_gnt_idx), .beat_cnt(a_beat_cnt)
    );

    vldrdy_rr_arbiter #(.NSRC(4), .DWIDTH(16), .BURST_LEN(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en),
        .src_val(src_val), .src_rdy(b_src_rdy), .src_data(b_src_data),
        .dst_val(b_dst_val), .dst_rdy(dst_rdy), .dst_data(b_dst_data),
        .gnt_vld(b_gnt_vld), .gnt_idx(b_gnt_idx), .beat_cnt(b_beat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            h = 16'h0000;
            if (srcq[i].size() > 0) h = srcq[i][0];
            src_val[i] = en_src[i] && (srcq[i].size() > 0);
            a_src_data[i*8 +: 8]   = src_val[i] ? h[7:0] : 8'h00;
            b_src_data[i*16 +: 16] = src_val[i] ? h : 16'h0000;
        end
    endtask

    // One cycle: drive at negedge, observe 1 time unit later, score, advance.
    task automatic tick();
        logic [19:0] e;
        logic [3:0]  exp_rdy;
        drive();
        #1;
        o_dval = sel ? b_dst_val : a_dst_val;
        o_data = sel ? b_dst_data : {8'h00, a_dst_data};
        o_gvld = sel ? b_gnt_vld : a_gnt_vld;
        o_gidx = sel ? b_gnt_idx : a_gnt_idx;
        o_srdy = sel ? b_src_rdy : a_src_rdy;
        o_beat = sel ? b_beat_cnt : a_beat_cnt;
        o_hs   = o_dval & dst_rdy;
        exp_rdy = (o_gvld && cfg_en && rst_n) ? (4'(dst_rdy) << o_gidx) : 4'h0;
        check("src_rdy", {28'h0, o_srdy}, {28'h0, exp_rdy});
        if (o_hs) begin
            check("sb_nonempty", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dst_data", {16'h0, o_data}, {16'h0, e[15:0]});
                check("hs_gnt_idx", {30'h0, o_gidx}, {30'h0, e[17:16]});
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (src_val[i] && o_srdy[i]) void'(srcq[i].pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_until_empty(input int bound, output int cycles);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < bound) begin
            tick();
            cycles++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        rst_n   = 1'b0;
        cfg_en  = 1'b1;
        dst_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt_vld", {31'h0, a_gnt_vld}, 32'h0);
        check("rst_gnt_idx", {30'h0, a_gnt_idx}, 32'h0);
        check("rst_beat_cnt", {16'h0, a_beat_cnt}, 32'h0);
        check("rst_dst_val", {31'h0, a_dst_val}, 32'h0);
        check("rst_src_rdy", {28'h0, a_src_rdy}, 32'h0);
        rst_n = 1'b1;

        // Idle after reset with no requests.
        for (int t = 0; t < 10; t++) begin
            tick();
            check("idle_dst_val", {31'h0, o_dval}, 32'h0);
            check("idle_gnt_vld", {31'h0, o_gvld}, 32'h0);
            check("idle_gnt_idx", {30'h0, o_gidx}, 32'h0);
            check("idle_beat_cnt", {16'h0, o_beat}, 32'h0);
        end

        // Single source: two bursts of 4 separated by one idle cycle.
        for (int k = 0; k < 8; k++) begin
            srcq[2].push_back(16'(16'h10 + k));
            exp_q.push_back({4'd2, 16'(16'h10 + k)});
        end
        pat = 10'b1111011110;
        for (int t = 0; t < 10; t++) begin
            tick();
            check("single_hs", {31'h0, o_hs}, {31'h0, pat[t]});
        end
        check("single_beat_cnt", {16'h0, a_beat_cnt}, 32'd8);
        check("single_drained", exp_q.size(), 0);
        tick();

        // Fairness: all sources busy, order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 8; k++)
                srcq[s].push_back(16'(s*16 + k));
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 4; s++)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({4'(s), 16'(s*16 + r*4 + k)});
        run_until_empty(200, n_cyc);
        check("rr_cycles", n_cyc, 40);
        check("rr_beat_cnt", {16'h0, a_beat_cnt}, 32'd32);

        // Backpressure mid-burst on source 1.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            srcq[1].push_back(16'(16'hA0 + k));
            exp_q.push_back({4'd1, 16'(16'hA0 + k)});
        end
        tick();
        tick();
        dst_rdy = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("bp_dst_val", {31'h0, o_dval}, 32'h1);
            check("bp_dst_data", {16'h0, o_data}, 32'hA1);
            check("bp_gnt_idx", {30'h0, o_gidx}, 32'h1);
            check("bp_gnt_vld", {31'h0, o_gvld}, 32'h1);
        end
        dst_rdy = 1'b1;
        run_until_empty(20, n_cyc);
        check("bp_tail_cycles", n_cyc, 3);
        check("bp_beat_cnt", {16'h0, a_beat_cnt}, 32'd4);

        // Early release of source 3 after two beats; next grant goes to 0.
        do_reset();
        for (int k = 0; k < 4; k++) srcq[3].push_back(16'(16'hB0 + k));
        exp_q.push_back({4'd3, 16'hB0});
        exp_q.push_back({4'd3, 16'hB1});
        tick();
        tick();
        tick();
        en_src[3] = 1'b0;
        srcq[0].push_back(16'hC0);
        srcq[0].push_back(16'hC1);
        srcq[1].push_back(16'hD0);
        exp_q.push_back({4'd0, 16'hC0});
        exp_q.push_back({4'd0, 16'hC1});
        exp_q.push_back({4'd1, 16'hD0});
        exp_q.push_back({4'd3, 16'hB2});
        exp_q.push_back({4'd3, 16'hB3});
        tick();
        check("early_dst_val", {31'h0, o_dval}, 32'h0);
        en_src[3] = 1'b1;
        tick();
        check("early_idle", {31'h0, o_gvld}, 32'h0);
        run_until_empty(40, n_cyc);

        // cfg_en dropped mid-burst for three cycles.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            srcq[1].push_back(16'(16'hE0 + k));
            exp_q.push_back({4'd1, 16'(16'hE0 + k)});
        end
        srcq[2].push_back(16'hF0);
        srcq[2].push_back(16'hF1);
        exp_q.push_back({4'd2, 16'hF0});
        exp_q.push_back({4'd2, 16'hF1});
        tick();
        tick();
        tick();
        cfg_en = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("dis_dst_val", {31'h0, o_dval}, 32'h0);
            check("dis_src_rdy", {28'h0, o_srdy}, 32'h0);
        end
        cfg_en = 1'b1;
        run_until_empty(40, n_cyc);
        check("dis_beat_cnt", {16'h0, a_beat_cnt}, 32'd8);

        // 16-bit, single-beat bursts: alternating grants.
        sel = 1'b1;
        do_reset();
        srcq[0].push_back(16'h1234);
        srcq[0].push_back(16'h5678);
        srcq[1].push_back(16'h9ABC);
        srcq[1].push_back(16'hDEF0);
        exp_q.push_back({4'd0, 16'h1234});
        exp_q.push_back({4'd1, 16'h9ABC});
        exp_q.push_back({4'd0, 16'h5678});
        exp_q.push_back({4'd1, 16'hDEF0});
        run_until_empty(40, n_cyc);
        check("w16_cycles", n_cyc, 8);
        check("w16_beat_cnt", {16'h0, b_beat_cnt}, 32'd4);

        // Reset asserted while BUSY on source 1.
        srcq[1].push_back(16'h3333);
        tick();
        check("w16_busy", {31'h0, b_gnt_vld}, 32'h1);
        rst_n = 1'b0;
        srcq[0].push_back(16'h1111);
        tick();
        check("rstbusy_dst_val", {31'h0, o_dval}, 32'h0);
        check("rstbusy_gnt_vld", {31'h0, b_gnt_vld}, 32'h0);
        check("rstbusy_gnt_idx", {30'h0, b_gnt_idx}, 32'h0);
        check("rstbusy_beat_cnt", {16'h0, b_beat_cnt}, 32'h0);
        check("rstbusy_src_rdy", {28'h0, b_src_rdy}, 32'h0);
        rst_n = 1'b1;
        exp_q.push_back({4'd0, 16'h1111});
        exp_q.push_back({4'd1, 16'h3333});
        run_until_empty(40, n_cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vldrdy_rr_arbiter.md
Name: vldrdy_rr_arbiter

Overview:
- Round-robin arbiter that shares one valid/ready sink among NSRC valid/ready source streams.
- Grants one source at a time and holds the grant for a burst of up to BURST_LEN beats.
- Sits between several stream producers and a single consumer, such as the vldrdy slave sink in benches or a downstream packer in RTL.
- Also provides grant status and a total beat count.

Parameters:
- NSRC, 4, number of source streams (2..16).
- DWIDTH, 8, data width per beat (8 or 16).
- BURST_LEN, 4, maximum beats per grant (>=1).
- CNT_W, 16, width of the total beat counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_en  input  1  enable, active high; stream protocol may be violated when it is deasserted.
- src_val  input  NSRC  per-source valid.
- src_rdy  output  NSRC  per-source ready.
- src_data  input  NSRC*DWIDTH  per-source data; source i occupies bits [i*DWIDTH +: DWIDTH]; held steady while valid.
- dst_val  output  1  sink valid.
- dst_rdy  input  1  sink ready.
- dst_data  output  DWIDTH  sink data.
- gnt_vld  output  1  a grant is active (state BUSY).
- gnt_idx  output  $clog2(NSRC)  currently or last granted source.
- beat_cnt  output  CNT_W  total dst handshakes since reset.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, gnt_vld=0, gnt_idx=0, last_gnt=NSRC-1, so source 0 has first priority.
  - burst_cnt=0, beat_cnt=0.
  - dst_val=0, src_rdy=0.
  - Reset overrides everything, including mid-burst; no beat is accepted in the reset cycle.
- Definitions:
  - Handshake (hs) = dst_val & dst_rdy.
  - dst_* and src_rdy are combinational from the registered grant plus the live inputs.
- State IDLE:
  - dst_val=0, all src_rdy=0, dst_data=0.
  - If cfg_en and |src_val: pick the first i with src_val[i]=1, scanning last_gnt+1, last_gnt+2, ... modulo NSRC.
  - Register gnt_idx=i, burst_cnt=0, go to BUSY. Arbitration latency is one cycle.
- State BUSY:
  - dst_val=src_val[gnt_idx], dst_data=src_data[gnt_idx].
  - src_rdy[gnt_idx]=dst_rdy; all other src_rdy=0.
  - On hs: beat_cnt++ (wraps at 2^CNT_W). If burst_cnt==BURST_LEN-1, set last_gnt=gnt_idx and go to IDLE; else burst_cnt++.
  - If src_val[gnt_idx]==0: there is no pending beat, so set last_gnt=gnt_idx and go to IDLE (early release).
  - The grant never changes while dst_val=1 and the beat is not accepted.
- Fixed one-cycle bubble: there is always one IDLE cycle between consecutive bursts, even when the same source re-requests.
- cfg_en=0:
  - Forces dst_val=0 and src_rdy=0 combinationally, so no hs can occur.
  - Next state is IDLE and burst_cnt is cleared.
  - last_gnt and beat_cnt are retained.
- BURST_LEN=1: every hs releases the grant.
- Only one source requesting: that source is re-granted after each release.
- hs on the final beat while other sources request: next cycle is IDLE; the cycle after that is BUSY with the next round-robin source.
- gnt_vld=1 exactly in BUSY. gnt_idx holds its value in IDLE.

Decomposition:
- Package vldrdy_pkg:
  - state enum (IDLE, BUSY);
  - function rr_pick(req, last) returning the index and a found flag;
  - localparam IDX_W=$clog2(NSRC) is computed in the module.
- One natural sub-module, rr_prio_sel:
  - combinational round-robin selector with inputs req[NSRC] and last[IDX_W];
  - outputs idx and found;
  - reusable by other arbiters in the codebase.

Test Plan:
- Reset/idle: reset then release rst_n with cfg_en=1 and all src_val=0 for 10 cycles -> dst_val=0, src_rdy=0, gnt_vld=0, gnt_idx=0, beat_cnt=0 throughout.
- Single source: src_val[2]=1 continuously with data 0x10,0x11,... and dst_rdy=1, BURST_LEN=4 -> bursts of 4 beats (0x10-0x13, then 0x14-0x17) separated by one idle cycle; beat_cnt=8 after two bursts.
- Round-robin fairness: all 4 sources valid continuously, dst_rdy=1 -> grant order 0,1,2,3,0. Each burst is exactly 4 beats, and the sink receives per-source data in order.
- Backpressure: source 1 granted, dst_rdy low for 5 cycles mid-burst -> dst_val stays 1 and dst_data stays stable; gnt_idx does not change; burst_cnt frozen; no beat lost or duplicated.
- Early release and mid-burst events:
  - src 3 deasserts valid after 2 accepted beats -> next cycle IDLE, last_gnt=3, so the next grant goes to src 0.
  - cfg_en dropped mid-burst for 3 cycles -> dst_val=0 and src_rdy=0 immediately; on re-enable, arbitration restarts after last_gnt.
- DWIDTH=16 with BURST_LEN=1 and a sync reset asserted while BUSY:
  - Before reset: alternating grants 0,1,0,1 on single beats; 16-bit data passes intact.
  - Reset asserted while BUSY: next cycle IDLE, outputs 0, beat_cnt=0; src 0 is granted first after reset is released.
